// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR coefficient bank and its sample strobe.
`default_nettype none

package fir_pkg;
  localparam int TAPS = 10;
  localparam int CW   = 16;
  localparam int DIV  = 40;
  localparam int DIV_W = $clog2(DIV);

  // First out-of-range tap index on the 4-bit write address
  localparam logic [3:0] TAPS_LIM = 4'(TAPS);

  typedef logic signed [CW-1:0] coeff_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/sample_strobe_gen.sv
// Free-running divider producing a one-cycle sample strobe every DIV clocks.
`default_nettype none

module sample_strobe_gen #(
  parameter int DIV = 40
) (
  input  logic iClk_12M,
  input  logic iRsn,
  output logic oEnSample_300k
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Decoded from the registered count, so it is glitch-free and zero in reset
  assign oEnSample_300k = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient banks with atomic commit on the sample strobe edge.
`default_nettype none

module fir_coeff_bank
  import fir_pkg::*;
(
  input  logic          iClk_12M,
  input  logic          iRsn,
  input  logic          iWrValid,
  output logic          oWrReady,
  input  logic [3:0]    iWrAddr,
  input  logic [CW-1:0] iWrData,
  input  logic          iCommit,
  output logic          oCommitDone,
  output logic          oErrAddr,
  output logic          oBusy,
  output logic          oEnSample_300k,
  output logic [CW-1:0] oCoeff1,
  output logic [CW-1:0] oCoeff2,
  output logic [CW-1:0] oCoeff3,
  output logic [CW-1:0] oCoeff4,
  output logic [CW-1:0] oCoeff5,
  output logic [CW-1:0] oCoeff6,
  output logic [CW-1:0] oCoeff7,
  output logic [CW-1:0] oCoeff8,
  output logic [CW-1:0] oCoeff9,
  output logic [CW-1:0] oCoeff10
);

  state_t state;
  coeff_t shadow [TAPS];
  coeff_t active [TAPS];
  logic   wr_accept;

  sample_strobe_gen #(
    .DIV(DIV)
  ) u_strobe (
    .iClk_12M      (iClk_12M),
    .iRsn          (iRsn),
    .oEnSample_300k(oEnSample_300k)
  );

  // Ready is only ever high in IDLE, so this also gates writes to IDLE
  assign wr_accept = iWrValid && oWrReady;

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state       <= IDLE;
      oWrReady    <= 1'b0;
      oBusy       <= 1'b0;
      oCommitDone <= 1'b0;
      oErrAddr    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      oCommitDone <= 1'b0;
      oErrAddr    <= 1'b0;

      if (wr_accept) begin
        if (iWrAddr < TAPS_LIM) begin
          for (int i = 0; i < TAPS; i++) begin
            if (iWrAddr == 4'(i)) shadow[i] <= iWrData;
          end
        end else begin
          oErrAddr <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (iCommit) begin
            state    <= PEND;
            oWrReady <= 1'b0;
            oBusy    <= 1'b1;
          end else begin
            oWrReady <= 1'b1;
            oBusy    <= 1'b0;
          end
        end
        PEND: begin
          // The MAC uses the old set on this edge; the new set applies next sample
          if (oEnSample_300k) begin
            for (int i = 0; i < TAPS; i++) active[i] <= shadow[i];
            state       <= IDLE;
            oCommitDone <= 1'b1;
            oWrReady    <= 1'b1;
            oBusy       <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          oWrReady <= 1'b0;
          oBusy    <= 1'b0;
        end
      endcase
    end
  end

  assign oCoeff1  = active[0];
  assign oCoeff2  = active[1];
  assign oCoeff3  = active[2];
  assign oCoeff4  = active[3];
  assign oCoeff5  = active[4];
  assign oCoeff6  = active[5];
  assign oCoeff7  = active[6];
  assign oCoeff8  = active[7];
  assign oCoeff9  = active[8];
  assign oCoeff10 = active[9];

endmodule

`default_nettype wire

// File: tb/tb_fir_coeff_bank.sv
// Directed testbench for fir_coeff_bank with hand-computed expectations.
`default_nettype none

module tb_fir_coeff_bank;

  logic        clk = 1'b0;
  logic        rsn;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        commit;
  logic        commit_done;
  logic        err_addr;
  logic        busy;
  logic        en_sample;
  logic [15:0] co [10];
  logic [15:0] exp_c [10];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  fir_coeff_bank dut (
    .iClk_12M      (clk),
    .iRsn          (rsn),
    .iWrValid      (wr_valid),
    .oWrReady      (wr_ready),
    .iWrAddr       (wr_addr),
    .iWrData       (wr_data),
    .iCommit       (commit),
    .oCommitDone   (commit_done),
    .oErrAddr      (err_addr),
    .oBusy         (busy),
    .oEnSample_300k(en_sample),
    .oCoeff1       (co[0]),
    .oCoeff2       (co[1]),
    .oCoeff3       (co[2]),
    .oCoeff4       (co[3]),
    .oCoeff5       (co[4]),
    .oCoeff6       (co[5]),
    .oCoeff7       (co[6]),
    .oCoeff8       (co[7]),
    .oCoeff9       (co[8]),
    .oCoeff10      (co[9])
  );

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cyc=%0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic chk_coeffs(input string tag);
    for (int i = 0; i < 10; i++) chk($sformatf("%s_coeff%0d", tag, i + 1), co[i], exp_c[i]);
  endtask

  // Sample point: 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_phase(input int p);
    while (cyc % 40 != p) tick();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!commit_done && n < 45) begin
      tick();
      n++;
    end
    chk(tag, 16'(commit_done), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rsn      = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    commit   = 1'b0;
    for (int i = 0; i < 10; i++) exp_c[i] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 16'(wr_ready), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(commit_done), 16'd0);
    chk("rst_err", 16'(err_addr), 16'd0);
    chk("rst_strobe", 16'(en_sample), 16'd0);
    chk_coeffs("rst");

    // Idle 120 cycles: strobe only at 39, 79, 119
    rsn = 1'b1;
    cyc = 0;
    for (int k = 0; k < 120; k++) begin
      chk("idle_strobe", 16'(en_sample), (k % 40 == 39) ? 16'd1 : 16'd0);
      if (k > 0) chk("idle_ready", 16'(wr_ready), 16'd1);
      tick();
    end
    chk("idle_busy", 16'(busy), 16'd0);
    chk_coeffs("idle");

    // Load taps 0..9 with 1..10, commit at phase 5
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 4'(i);
      wr_data  = 16'(i + 1);
      tick();
    end
    wr_valid = 1'b0;
    chk("load_err", 16'(err_addr), 16'd0);
    chk_coeffs("load_not_visible");
    wait_phase(5);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    while (cyc % 40 != 39) begin
      chk("pend_busy", 16'(busy), 16'd1);
      chk("pend_ready", 16'(wr_ready), 16'd0);
      chk("pend_done", 16'(commit_done), 16'd0);
      chk("pend_coeff1", co[0], 16'd0);
      tick();
    end
    chk("pend_strobe", 16'(en_sample), 16'd1);
    chk_coeffs("pre_commit");
    tick();
    for (int i = 0; i < 10; i++) exp_c[i] = 16'(i + 1);
    chk_coeffs("commit1");
    chk("commit1_done", 16'(commit_done), 16'd1);
    chk("commit1_busy", 16'(busy), 16'd0);
    chk("commit1_ready", 16'(wr_ready), 16'd1);
    tick();
    chk("commit1_done_pulse", 16'(commit_done), 16'd0);

    // Commit requested on a strobe-high cycle waits a full period
    wr_valid = 1'b1;
    wr_addr  = 4'd0;
    wr_data  = 16'd100;
    tick();
    wr_valid = 1'b0;
    wait_phase(39);
    chk("strobe_commit_strobe", 16'(en_sample), 16'd1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    while (cyc % 40 != 39) begin
      chk("late_busy", 16'(busy), 16'd1);
      chk("late_done", 16'(commit_done), 16'd0);
      chk("late_coeff1", co[0], 16'd1);
      tick();
    end
    tick();
    exp_c[0] = 16'd100;
    chk_coeffs("commit2");
    chk("commit2_done", 16'(commit_done), 16'd1);

    // Out-of-range address is dropped and flagged
    wr_valid = 1'b1;
    wr_addr  = 4'd12;
    wr_data  = 16'h7FFF;
    tick();
    wr_valid = 1'b0;
    chk("err_pulse", 16'(err_addr), 16'd1);
    tick();
    chk("err_clear", 16'(err_addr), 16'd0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_done("commit3_done");
    chk_coeffs("commit3");
    tick();

    // Write together with commit is included; writes held off while pending
    wr_valid = 1'b1;
    wr_addr  = 4'd3;
    wr_data  = 16'hFFFE;
    commit   = 1'b1;
    tick();
    commit   = 1'b0;
    wr_addr  = 4'd5;
    wr_data  = 16'h1234;
    chk("same_cycle_busy", 16'(busy), 16'd1);
    begin
      int n = 0;
      while (!commit_done && n < 45) begin
        chk("held_ready", 16'(wr_ready), 16'd0);
        tick();
        n++;
      end
    end
    chk("commit4_done", 16'(commit_done), 16'd1);
    exp_c[3] = 16'hFFFE;
    chk_coeffs("commit4");
    tick();
    wr_valid = 1'b0;

    // Reset while pending clears everything asynchronously
    wait_phase(5);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", 16'(busy), 16'd1);
    #2;
    rsn = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) exp_c[i] = '0;
    chk_coeffs("async_rst");
    chk("async_rst_busy", 16'(busy), 16'd0);
    chk("async_rst_ready", 16'(wr_ready), 16'd0);
    chk("async_rst_done", 16'(commit_done), 16'd0);
    chk("async_rst_strobe", 16'(en_sample), 16'd0);
    tick();
    tick();
    rsn = 1'b1;
    cyc = 0;
    tick();
    chk("post_rst_ready", 16'(wr_ready), 16'd1);
    chk("post_rst_busy", 16'(busy), 16'd0);
    chk("post_rst_done", 16'(commit_done), 16'd0);
    while (!en_sample && cyc < 50) tick();
    chk("post_rst_strobe_cyc", 16'(cyc), 16'd39);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_done("post_rst_commit_done");
    chk_coeffs("post_rst_commit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
